// File: rtl/shiftram_pkg.sv
// Shared types for the shiftram family of blocks.
// The frame-reversal FSM state lives here so that other shifter blocks can reuse it.
package shiftram_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } shiftram_rev_state_e;

endpackage

// File: rtl/shiftram_mem.sv
// DEPTH x DWIDTH register array: one synchronous write port, one asynchronous read port.
// Not reset; the contents are only valid where they have been written.
module shiftram_mem #(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 256,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [DWIDTH-1:0] rd_data
);

   logic [DWIDTH-1:0] mem [DEPTH];

   // write port: one word per accepted cycle
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/shiftram_reverse.sv
// Frame-reversing buffer: captures up to DEPTH words, then emits them last-in/first-out.
// Optional macro SHIFTRAM_REVERSE_STATS_EN adds the frame_len and trunc status outputs.
module shiftram_reverse
   import shiftram_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int DEPTH  = 256,
   localparam int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] d,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] q,
   output logic              out_last
`ifdef SHIFTRAM_REVERSE_STATS_EN
   ,
   output logic [AWIDTH:0]   frame_len,
   output logic              trunc
`endif
);

   shiftram_rev_state_e state_q, state_d;
   logic [AWIDTH-1:0]   wptr_q, wptr_d;
   logic [AWIDTH-1:0]   rptr_q, rptr_d;
   logic                remain_q, remain_d;
   logic                out_valid_q, out_valid_d;
   logic [DWIDTH-1:0]   q_q, q_d;
   logic                out_last_q, out_last_d;

   logic                wr_en;
   logic                at_end;
   logic                enter_drain;
   logic                load;
   logic                done;
   logic [DWIDTH-1:0]   rd_data;

   assign in_ready    = (state_q == FILL);
   assign wr_en       = in_valid && in_ready;
   assign at_end      = (wptr_q == AWIDTH'(DEPTH - 1));
   assign enter_drain = wr_en && (in_last || at_end);
   // remain_q tracks whether rptr still points at an unread word
   assign load        = (state_q == DRAIN) && remain_q
                        && (!out_valid_q || out_ready);
   assign done        = out_valid_q && out_ready && out_last_q;

   shiftram_mem #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AWIDTH (AWIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wptr_q),
      .wr_data (d),
      .rd_addr (rptr_q),
      .rd_data (rd_data)
   );

   // next-state: capture in FILL, reverse-read into the output register in DRAIN
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      remain_d    = remain_q;
      out_valid_d = out_valid_q;
      q_d         = q_q;
      out_last_d  = out_last_q;
      unique case (state_q)
         FILL: begin
            if (enter_drain) begin
               rptr_d   = wptr_q;
               remain_d = 1'b1;
               state_d  = DRAIN;
            end else if (wr_en) begin
               wptr_d = wptr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (done) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               wptr_d      = '0;
               state_d     = FILL;
            end else if (load) begin
               q_d         = rd_data;
               out_valid_d = 1'b1;
               out_last_d  = (rptr_q == '0);
               remain_d    = (rptr_q != '0);
               rptr_d      = rptr_q - 1'b1;
            end
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         wptr_q      <= '0;
         rptr_q      <= '0;
         remain_q    <= 1'b0;
         out_valid_q <= 1'b0;
         q_q         <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         remain_q    <= remain_d;
         out_valid_q <= out_valid_d;
         q_q         <= q_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign q         = q_q;
   assign out_last  = out_last_q;

`ifdef SHIFTRAM_REVERSE_STATS_EN
   logic [AWIDTH:0] frame_len_q, frame_len_d;
   logic            trunc_q, trunc_d;

   // frame statistics latched on each DRAIN entry
   always_comb begin
      frame_len_d = frame_len_q;
      trunc_d     = trunc_q;
      if ((state_q == FILL) && enter_drain) begin
         frame_len_d = {1'b0, wptr_q} + 1'b1;
         trunc_d     = at_end && !in_last;
      end
   end

   // statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_len_q <= '0;
         trunc_q     <= 1'b0;
      end else begin
         frame_len_q <= frame_len_d;
         trunc_q     <= trunc_d;
      end
   end

   assign frame_len = frame_len_q;
   assign trunc     = trunc_q;
`endif

endmodule

// File: tb/tb_shiftram_reverse.sv
// Self-checking bench for shiftram_reverse (DEPTH=8) with a reverse-order scoreboard.
// Builds with or without SHIFTRAM_REVERSE_STATS_EN.
module tb_shiftram_reverse;

   localparam int DW = 16;
   localparam int DP = 8;
   localparam int AW = $clog2(DP);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] d;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] q;
   logic          out_last;
`ifdef SHIFTRAM_REVERSE_STATS_EN
   logic [AW:0]   frame_len;
   logic          trunc;
`endif

   int errors = 0;
   int checks = 0;
   logic [DW:0] exp_q [$];
   logic [DW-1:0] last_data;

   shiftram_reverse #(
      .DWIDTH (DW),
      .DEPTH  (DP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .out_last  (out_last)
`ifdef SHIFTRAM_REVERSE_STATS_EN
      ,
      .frame_len (frame_len),
      .trunc     (trunc)
`endif
   );

   always #5 clk = ~clk;

   task automatic send(input logic [DW-1:0] base, input int n,
                       input bit lst);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         d        = base + DW'(i);
         in_last  = lst && (i == n - 1);
         in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready word %0d got=%b exp=1", i, in_ready);
         end
         exp_q.push_front({(i == 0), base + DW'(i)});
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int n, input bit rnd, input bit tput,
                        input bit fin);
      int got = 0;
      int cyc = 0;
      int first = -1;
      bit stall = 0;
      logic [DW-1:0] pq = '0;
      logic pl = 1'b0;
      logic [DW:0] e;
      while (got < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            checks++;
            if (q !== pq || out_last !== pl) begin
               errors++;
               $display("FAIL stall_hold q=%h last=%b exp q=%h last=%b",
                        q, out_last, pq, pl);
            end
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_in_ready cyc %0d got=%b exp=0", cyc, in_ready);
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid === 1'b1) begin
            if (first < 0) first = cyc;
            if (out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_output q=%h exp=none", q);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_last, q} !== e) begin
                     errors++;
                     $display("FAIL out_word %0d got last=%b q=%h exp last=%b q=%h",
                              got, out_last, q, e[DW], e[DW-1:0]);
                  end
               end
               last_data = q;
               got++;
            end
         end else if (tput && first >= 0) begin
            checks++;
            errors++;
            $display("FAIL throughput_gap cyc %0d out_valid=0 exp=1", cyc);
         end
         stall = (out_valid === 1'b1) && !out_ready;
         pq    = q;
         pl    = out_last;
      end
      checks++;
      if (got < n) begin
         errors++;
         $display("FAIL drain_timeout got=%0d exp=%0d", got, n);
      end
      if (tput) begin
         checks++;
         if (first != 2) begin
            errors++;
            $display("FAIL latency first_valid=%0d exp=2", first);
         end
      end
      if (fin) begin
         @(negedge clk);
         out_ready = 1'b0;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== last_data) begin
            errors++;
            $display("FAIL frame_done in_ready=%b out_valid=%b q=%h exp 1 0 %h",
                     in_ready, out_valid, q, last_data);
         end
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d exp=0", exp_q.size());
         end
      end
   endtask

   task automatic pulse_reset(input string tag);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || q !== '0 || out_last !== 1'b0
          || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s v=%b q=%h l=%b rdy=%b exp 0 0000 0 1",
                  tag, out_valid, q, out_last, in_ready);
      end
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_stats(input int len, input bit tr);
`ifdef SHIFTRAM_REVERSE_STATS_EN
      checks++;
      if (frame_len !== (AW+1)'(len) || trunc !== tr) begin
         errors++;
         $display("FAIL stats len=%0d trunc=%b exp len=%0d trunc=%b",
                  frame_len, trunc, len, tr);
      end
`else
      if (len < 0 || tr === 1'bx) $display("stats n/a");
`endif
   endtask

   task automatic test_reset();
      send(16'h0055, 2, 1'b1);
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || q !== 16'h0056) begin
         errors++;
         $display("FAIL pre_reset v=%b q=%h exp 1 0056", out_valid, q);
      end
      pulse_reset("reset_mid_drain");
   endtask

   task automatic test_basic();
      send(16'h0001, 5, 1'b1);
      drain(5, 1'b0, 1'b1, 1'b1);
      check_stats(5, 1'b0);
   endtask

   task automatic test_trunc();
      send(16'h0010, 8, 1'b0);
      drain(8, 1'b0, 1'b1, 1'b1);
      check_stats(8, 1'b1);
   endtask

   task automatic test_backpressure();
      send(16'h0100, 6, 1'b1);
      drain(6, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_single();
      send(16'hABCD, 1, 1'b1);
      drain(1, 1'b0, 1'b1, 1'b1);
      check_stats(1, 1'b0);
   endtask

   task automatic test_abort();
      send(16'h0031, 5, 1'b1);
      drain(2, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      pulse_reset("reset_abort");
      send(16'h0001, 2, 1'b1);
      drain(2, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      d         = '0;
      out_ready = 1'b0;
      last_data = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_basic();
      test_trunc();
      test_backpressure();
      test_single();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shiftram_reverse.md
Name: shiftram_reverse

Overview:
- Frame-reversing buffer for the shifter family. Shift-register RAMs emit words first-in/first-out; this block emits each frame last-in/first-out.
- Captures a frame of up to DEPTH words on a valid/ready input stream, then drains it in reverse order on a valid/ready output stream.
- Placed downstream of shiftram delay lines wherever time-reversed sample order is needed.

Parameters:
- DWIDTH, 16, data word width.
- DEPTH, 256, maximum frame length in words. Power of 2, >= 2.
- AWIDTH, $clog2(DEPTH), localparam, pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts input. Combinational: high iff state == FILL.
- d  input  DWIDTH  input word.
- in_last  input  1  marks the final word of a frame.
- out_valid  output  DWIDTH-independent, 1  output word present (registered).
- out_ready  input  1  downstream accepts output.
- q  output  DWIDTH  output word (registered).
- out_last  output  1  marks the final output word of the frame, i.e. the first word captured (registered).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state FILL, wptr 0, rptr 0, out_valid 0, q 0, out_last 0. in_ready is therefore 1 after reset. Memory contents are not reset.
- Input handshake: a word is accepted on a rising edge with in_valid && in_ready. d and in_last are ignored otherwise.
- FILL state:
  - An accepted word is written to mem[wptr].
  - If in_last, or wptr == DEPTH-1: set rptr <= wptr and go to DRAIN. Hitting DEPTH-1 truncates the frame; in_last on that same word is equivalent.
  - Otherwise wptr increments.
- DRAIN state:
  - in_ready is 0.
  - The output register loads when (!out_valid || out_ready) and words remain, setting q <= mem[rptr], out_valid <= 1, out_last <= (rptr == 0). rptr then decrements.
  - Latency: the final input word is accepted on edge k; out_valid rises after edge k+1.
  - Throughput is 1 word/cycle with out_ready held high.
- Output stalls: while out_valid && !out_ready, q and out_last hold stable.
- Frame completion: on the edge where the out_last word completes its handshake:
  - out_valid <= 0, out_last <= 0, wptr <= 0, state <= FILL.
  - in_ready is high the following cycle.
  - q retains its last value.
- Single-word frame: rptr = 0, so one output with out_last = 1.
- No input overflow is possible: in_ready is low for the entire drain.
- Reset mid-operation discards the frame immediately (asynchronous). Outputs go to their reset values.

Optional Feature:
- Macro SHIFTRAM_REVERSE_STATS_EN.
- Defined: adds output ports frame_len [AWIDTH:0] and trunc [1].
  - frame_len is registered on entry to DRAIN with the word count (wptr + 1) and holds until the next DRAIN entry. Reset value 0.
  - trunc is registered on DRAIN entry: 1 if the frame ended at DEPTH without in_last, else 0. Reset value 0.
- Undefined: the ports and logic are absent; core behaviour is identical.

Decomposition:
- Package shiftram_pkg holds typedef enum logic {FILL, DRAIN} shiftram_rev_state_e.
- One sub-module, shiftram_mem: DEPTH x DWIDTH register array with one synchronous write port and one asynchronous read port, no reset. Reusable by other shifter blocks.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> out_valid=0, q=0, out_last=0, in_ready=1 immediately. Reset checks are on the same cycle (asynchronous).
- DEPTH=8; send 1,2,3,4,5 with in_last on 5; out_ready=1 -> q=5,4,3,2,1 on consecutive cycles; out_last only with 1; in_ready=0 from the edge after 5 until the edge after 1.
- DEPTH=8; send 0x10..0x17 with in_last=0 -> truncated at 8 words; output 0x17..0x10 with out_last on 0x10. STATS build: frame_len=8, trunc=1.
- Backpressure: 6-word frame with out_ready random 50% -> q/out_last stable whenever out_valid && !out_ready; exact reverse sequence with no loss or duplication.
- Single word 0xABCD with in_last -> exactly one output 0xABCD with out_last=1; in_ready returns 1 the cycle after the handshake.
- Reset after 2 of 5 outputs, then frame 0x1,0x2 (in_last on 0x2) -> outputs 0x2,0x1 only; no residue of the aborted frame.
